u1_prefetch_scheduler: RTL and testbench
========================================

# u1_prefetch_scheduler

- Sequences burst reads of the processed-data BRAM (u1) into the downstream CPU data FIFO.
- Shares the single BRAM u1 request port with DMA writes.
- Keeps the FIFO filled using a credit counter, so no read is ever issued without guaranteed FIFO space.
- Bounds DMA write bursts so prefetch is never starved. The block sits between the DMA engine, the u1 BRAM controller and the data FIFO.

## Interface

- `ADDR_W`, 13, BRAM word-address width
- `DATA_W`, 32, data width
- `FIFO_DEPTH`, 16, downstream FIFO depth; initial credit count
- `MAX_WR_STREAK`, 8, maximum consecutive DMA write grants while a read is eligible

Ports:

- `wb_clk_i` in 1: the single clock
- `wb_rst_ni` in 1: asynchronous, active-low reset
- `cfg_start` in 1: one-cycle pulse that starts a prefetch job
- `cfg_base` in ADDR_W: first word address; sampled on `cfg_start`
- `cfg_len` in ADDR_W: number of words; sampled on `cfg_start`
- `busy` out 1: job active
- `done` out 1: one-cycle pulse when a job completes
- `err_rd_unexp` out 1: sticky; set by read data arriving with nothing in flight
- `dma_w_valid` in 1: DMA write request
- `dma_w_addr` in ADDR_W: DMA write address
- `dma_w_data` in DATA_W: DMA write data
- `dma_w_ready` out 1: combinational grant; a write transfers when valid & ready
- `bram_wr` out 1: 1 = write, 0 = read
- `bram_in_valid` out 1: request strobe
- `bram_addr` out ADDR_W: request address
- `bram_data_in` out DATA_W: write data
- `bram_rd_valid` in 1: read data valid from the u1 controller
- `bram_rd_data` in DATA_W: read data
- `fifo_push` out 1: push strobe to the data FIFO
- `fifo_data` out DATA_W: push data
- `fifo_pop` in 1: consumer popped one FIFO entry; returns one credit

## Operation

States:

- IDLE: `busy`=0. Only DMA writes are serviced.
  - `cfg_start` with `cfg_len`≠0: latch base/len, clear offset and streak, go to RUN.
  - `cfg_start` with `cfg_len`=0: emit `done` next cycle and stay in IDLE.
- RUN: per-cycle grant decision.
  - A read is eligible when remaining>0 and credit>0.
  - Grant the write if `dma_w_valid` and (no read eligible or streak<`MAX_WR_STREAK`). Otherwise grant the read if eligible.
  - Write grant: streak+1.
  - Read grant, or a cycle with no write granted: streak←0.
  - Read issue: addr=base+offset mod 2^ADDR_W (wraps from 0x1FFF to 0x0000); offset+1, remaining−1, credit−1, inflight+1.
  - remaining reaches 0 → DRAIN.
- DRAIN: reads are no longer issued and writes are still granted. When inflight=0, pulse `done` and go to IDLE.
- `cfg_start` while `busy`=1 is ignored; no state change.

Counters and arithmetic:

- credit: width clog2(FIFO_DEPTH+1).
  - Decrements on read issue, increments on `fifo_pop`. Both in the same cycle → unchanged.
  - A `fifo_pop` at credit=FIFO_DEPTH is ignored and saturates.
  - Credit persists across jobs and is reset only by `wb_rst_ni`.
- inflight:
  - Increments on read issue, decrements on `bram_rd_valid`. Both together → unchanged.
  - `bram_rd_valid` at inflight=0: data is dropped (no push) and `err_rd_unexp` is set.
- remaining: ADDR_W+1 bits.

Reset: asynchronous assert of `wb_rst_ni`=0, including mid-job.

- Return to IDLE; all counters 0; credit=FIFO_DEPTH.
- All outputs 0: `busy`, `done`, `err_rd_unexp`, `bram_*`, `fifo_*`.
- Read data that returns after reset is dropped and flagged per the inflight rule.

## Timing

- `dma_w_ready` is combinational from current state/counters and `dma_w_valid`.
- `bram_*` outputs are registered: a request granted in cycle N appears in cycle N+1 for exactly one cycle.
  - Idle cycles: `bram_in_valid`=0, addr/data=0.
- Read issue is also registered (N → N+1), so a single job's read requests are back-to-back when credit and no DMA writes allow.
- `fifo_push`/`fifo_data` are the registered `bram_rd_valid`/`bram_rd_data`: one cycle later.
- `done` is asserted the cycle after inflight reaches 0.
- `busy` goes 1 the cycle after `cfg_start` and 0 together with `done`.
- Block throughput is one BRAM request per cycle. BRAM read latency is irrelevant to correctness.

## Structure

- Shared package holds:
  - the state enum (IDLE/RUN/DRAIN);
  - the BRAM opcode constants (RD=0, WR=1);
  - the u1 address-region constants used by the address decoders.
- One sub-module, `credit_counter`: a saturating up/down counter with parameterised max. It is instantiated twice, for credit and for inflight.

## Test plan

- Reset, then `cfg_start` with base=0x0100, len=4, `fifo_pop` held high, BRAM model latency 10:
  - four reads at 0x0100–0x0103 on consecutive cycles;
  - four pushes in order;
  - `done` one cycle after the 4th return.
- len=20, FIFO_DEPTH=16, no pops:
  - exactly 16 reads issue, then the block stalls in RUN;
  - pop 4 → 4 more reads issue;
  - `done` after the 20th return.
- Write starvation: `dma_w_valid` constantly high during a len=8 job:
  - grants are 8 writes, 1 read, repeating;
  - with no job active, writes are granted every cycle.
- base=0x1FFE, len=4 → read addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- Corner cases:
  - `cfg_start` while busy is ignored;
  - len=0 gives `done` with no reads;
  - `fifo_pop` at credit=16 leaves credit at 16;
  - simultaneous issue and pop leaves credit unchanged.
- Reset mid-job (after 3 of 8 reads issued):
  - all outputs 0, IDLE;
  - late `bram_rd_valid` → no push, `err_rd_unexp`=1.

Source files
------------

// File: rtl/u1_prefetch_scheduler_pkg.sv
// Shared types and constants for the u1 prefetch scheduler: FSM states,
// BRAM request opcodes and the u1 word-address region.
package u1_prefetch_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic BRAM_OP_RD = 1'b0;
    localparam logic BRAM_OP_WR = 1'b1;

    localparam int                   U1_ADDR_W     = 13;
    localparam logic [U1_ADDR_W-1:0] U1_ADDR_FIRST = 13'h0000;
    localparam logic [U1_ADDR_W-1:0] U1_ADDR_LAST  = 13'h1FFF;

endpackage

// File: rtl/u1_prefetch_scheduler_credit_counter.sv
// Saturating up/down counter; inc and dec together hold the count, and it
// never wraps past MAX or below zero.
module credit_counter #(
    parameter int MAX     = 16,
    parameter int RST_VAL = 0,
    parameter int W       = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && (count_q != W'(MAX))) begin
            count_d = count_q + W'(1);
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= W'(RST_VAL);
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/u1_prefetch_scheduler.sv
// Arbitrates the shared u1 BRAM port between DMA writes and credit-gated
// prefetch reads that stream a configured window into the CPU data FIFO.
//
// state    | meaning
// ST_IDLE  | no job; only DMA writes are granted
// ST_RUN   | reads issue while words remain and FIFO credit exists
// ST_DRAIN | all reads issued; waiting for in-flight data to return
module u1_prefetch_scheduler
    import u1_prefetch_scheduler_pkg::*;
#(
    parameter int ADDR_W        = 13,
    parameter int DATA_W        = 32,
    parameter int FIFO_DEPTH    = 16,
    parameter int MAX_WR_STREAK = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_len,
    output logic              busy,
    output logic              done,
    output logic              err_rd_unexp,
    input  logic              dma_w_valid,
    input  logic [ADDR_W-1:0] dma_w_addr,
    input  logic [DATA_W-1:0] dma_w_data,
    output logic              dma_w_ready,
    output logic              bram_wr,
    output logic              bram_in_valid,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_data_in,
    input  logic              bram_rd_valid,
    input  logic [DATA_W-1:0] bram_rd_data,
    output logic              fifo_push,
    output logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_pop
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(MAX_WR_STREAK + 1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              bram_wr_q, bram_wr_d;
    logic              bram_in_valid_q, bram_in_valid_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0] bram_data_q, bram_data_d;
    logic              fifo_push_q, fifo_push_d;
    logic [DATA_W-1:0] fifo_data_q, fifo_data_d;

    logic [CW-1:0] credit;
    logic [CW-1:0] inflight;
    logic          rd_elig;
    logic          wr_grant;
    logic          rd_grant;
    logic          rd_accept;

    // Writes lose the port only once they have hogged it for a full streak
    // while a read is waiting.
    assign rd_elig     = (state_q == ST_RUN) && (remaining_q != '0) && (credit != '0);
    assign dma_w_ready = !rd_elig || (streak_q < SW'(MAX_WR_STREAK));
    assign wr_grant    = dma_w_valid && dma_w_ready;
    assign rd_grant    = rd_elig && !wr_grant;
    assign rd_accept   = bram_rd_valid && (inflight != '0);

    credit_counter #(.MAX(FIFO_DEPTH), .RST_VAL(FIFO_DEPTH), .W(CW)) u_credit (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .inc   (fifo_pop),
        .dec   (rd_grant),
        .count (credit)
    );

    credit_counter #(.MAX(FIFO_DEPTH), .RST_VAL(0), .W(CW)) u_inflight (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .inc   (rd_grant),
        .dec   (bram_rd_valid),
        .count (inflight)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        rd_addr_d   = rd_addr_q;
        done_d      = 1'b0;
        if (wr_grant) begin
            streak_d = (streak_q == SW'(MAX_WR_STREAK)) ? streak_q : streak_q + SW'(1);
        end else begin
            streak_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    streak_d = '0;
                    if (cfg_len != '0) begin
                        state_d     = ST_RUN;
                        rd_addr_d   = cfg_base;
                        remaining_d = {1'b0, cfg_len};
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (rd_grant) begin
                    rd_addr_d   = (rd_addr_q == ADDR_W'(U1_ADDR_LAST)) ? ADDR_W'(U1_ADDR_FIRST)
                                                                      : rd_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - (ADDR_W + 1)'(1);
                    if (remaining_q == (ADDR_W + 1)'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (inflight == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d          = (state_d != ST_IDLE);
        err_d           = err_q || (bram_rd_valid && (inflight == '0));
        bram_in_valid_d = wr_grant || rd_grant;
        bram_wr_d       = wr_grant ? BRAM_OP_WR : BRAM_OP_RD;
        bram_addr_d     = wr_grant ? dma_w_addr : (rd_grant ? rd_addr_q : '0);
        bram_data_d     = wr_grant ? dma_w_data : '0;
        fifo_push_d     = rd_accept;
        fifo_data_d     = rd_accept ? bram_rd_data : '0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q         <= ST_IDLE;
            remaining_q     <= '0;
            rd_addr_q       <= '0;
            streak_q        <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            bram_wr_q       <= 1'b0;
            bram_in_valid_q <= 1'b0;
            bram_addr_q     <= '0;
            bram_data_q     <= '0;
            fifo_push_q     <= 1'b0;
            fifo_data_q     <= '0;
        end else begin
            state_q         <= state_d;
            remaining_q     <= remaining_d;
            rd_addr_q       <= rd_addr_d;
            streak_q        <= streak_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            err_q           <= err_d;
            bram_wr_q       <= bram_wr_d;
            bram_in_valid_q <= bram_in_valid_d;
            bram_addr_q     <= bram_addr_d;
            bram_data_q     <= bram_data_d;
            fifo_push_q     <= fifo_push_d;
            fifo_data_q     <= fifo_data_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err_rd_unexp  = err_q;
    assign bram_wr       = bram_wr_q;
    assign bram_in_valid = bram_in_valid_q;
    assign bram_addr     = bram_addr_q;
    assign bram_data_in  = bram_data_q;
    assign fifo_push     = fifo_push_q;
    assign fifo_data     = fifo_data_q;

endmodule

// File: tb/tb_u1_prefetch_scheduler.sv
// Scoreboard bench for u1_prefetch_scheduler: directed jobs push expected BRAM
// requests and FIFO pushes; negedge monitors pop and compare them.
module tb_u1_prefetch_scheduler;

    localparam int LAT = 10;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic        cfg_start, busy, done, err_rd_unexp;
    logic [12:0] cfg_base, cfg_len;
    logic        dma_w_valid, dma_w_ready;
    logic [12:0] dma_w_addr;
    logic [31:0] dma_w_data;
    logic        bram_wr, bram_in_valid;
    logic [12:0] bram_addr;
    logic [31:0] bram_data_in;
    logic        bram_rd_valid = 1'b0;
    logic [31:0] bram_rd_data = 32'h0;
    logic        fifo_push, fifo_pop;
    logic [31:0] fifo_data;

    always #5 wb_clk_i = ~wb_clk_i;

    u1_prefetch_scheduler dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_ni     (wb_rst_ni),
        .cfg_start     (cfg_start),
        .cfg_base      (cfg_base),
        .cfg_len       (cfg_len),
        .busy          (busy),
        .done          (done),
        .err_rd_unexp  (err_rd_unexp),
        .dma_w_valid   (dma_w_valid),
        .dma_w_addr    (dma_w_addr),
        .dma_w_data    (dma_w_data),
        .dma_w_ready   (dma_w_ready),
        .bram_wr       (bram_wr),
        .bram_in_valid (bram_in_valid),
        .bram_addr     (bram_addr),
        .bram_data_in  (bram_data_in),
        .bram_rd_valid (bram_rd_valid),
        .bram_rd_data  (bram_rd_data),
        .fifo_push     (fifo_push),
        .fifo_data     (fifo_data),
        .fifo_pop      (fifo_pop)
    );

    typedef struct packed {
        logic        wr;
        logic [12:0] addr;
        logic [31:0] data;
    } req_t;

    req_t        exp_req[$];
    logic [31:0] exp_push[$];
    req_t        mon_req;
    logic [31:0] mon_push;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rd_cnt = 0;
    int          last_push_cyc = -1;
    logic        pv[LAT];
    logic [12:0] pa[LAT];

    always @(posedge wb_clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [12:0] a);
        return 32'hC0DE_0000 | {19'h0, a};
    endfunction

    task automatic push_rd(input logic [12:0] a, input logic with_push);
        exp_req.push_back('{wr: 1'b0, addr: a, data: 32'h0});
        if (with_push) exp_push.push_back(rd_word(a));
    endtask

    // BRAM read model: fixed latency, data derived from the address.
    initial for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pa[i] = '0; end
    always @(negedge wb_clk_i) begin
        bram_rd_valid = pv[LAT-1];
        bram_rd_data  = pv[LAT-1] ? rd_word(pa[LAT-1]) : 32'h0;
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
        end
        pv[0] = bram_in_valid && !bram_wr;
        pa[0] = bram_addr;
    end

    always @(negedge wb_clk_i) begin
        if (bram_in_valid) begin
            if (!bram_wr) rd_cnt++;
            if (exp_req.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bram_req unexpected got wr=%b addr=%h exp=none", bram_wr, bram_addr);
            end else begin
                mon_req = exp_req.pop_front();
                chk("bram_wr", {31'h0, bram_wr}, {31'h0, mon_req.wr});
                chk("bram_addr", {19'h0, bram_addr}, {19'h0, mon_req.addr});
                chk("bram_data", bram_data_in, mon_req.data);
            end
        end
        if (fifo_push) begin
            last_push_cyc = cyc;
            if (exp_push.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fifo_push unexpected got=%h exp=none", fifo_data);
            end else begin
                mon_push = exp_push.pop_front();
                chk("fifo_data", fifo_data, mon_push);
            end
        end
    end

    task automatic step();
        @(negedge wb_clk_i);
        #1;
    endtask

    task automatic wait_done(input string name, output int dc);
        dc = -1;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                dc = cyc;
                break;
            end
            step();
        end
        if (dc < 0) begin
            checks++;
            errors++;
            $display("FAIL %s got=no_done exp=done", name);
        end
    endtask

    task automatic pop_n(input int n);
        fifo_pop = 1'b1;
        repeat (n) step();
        fifo_pop = 1'b0;
    endtask

    task automatic start_job(input logic [12:0] base, input logic [12:0] len);
        cfg_base  = base;
        cfg_len   = len;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, r0, nd;
        cfg_start = 0; cfg_base = '0; cfg_len = '0;
        dma_w_valid = 0; dma_w_addr = '0; dma_w_data = '0; fifo_pop = 0;
        repeat (3) step();
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_done", {31'h0, done}, 0);
        chk("rst_err", {31'h0, err_rd_unexp}, 0);
        chk("rst_bram_valid", {31'h0, bram_in_valid}, 0);
        chk("rst_fifo_push", {31'h0, fifo_push}, 0);
        wb_rst_ni = 1'b1;
        step();
        chk("idle_ready", {31'h0, dma_w_ready}, 1);

        // Job 1: four back-to-back reads with pops held high.
        fifo_pop = 1'b1;
        for (int i = 0; i < 4; i++) push_rd(13'h0100 + 13'(i), 1'b1);
        start_job(13'h0100, 13'd4);
        chk("t1_busy", {31'h0, busy}, 1);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("t1_b2b", {31'h0, bram_in_valid}, 1);
            step();
        end
        chk("t1_gap", {31'h0, bram_in_valid}, 0);
        wait_done("t1_done", dc);
        chk("t1_done_lat", 32'(dc - last_push_cyc), 1);
        chk("t1_busy_at_done", {31'h0, busy}, 0);
        step();
        chk("t1_done_pulse", {31'h0, done}, 0);
        fifo_pop = 1'b0;

        // Job 2: len 20 without pops stalls after 16 credits.
        r0 = rd_cnt;
        for (int i = 0; i < 20; i++) push_rd(13'h0200 + 13'(i), 1'b1);
        start_job(13'h0200, 13'd20);
        repeat (40) step();
        chk("t2_stall_reads", 32'(rd_cnt - r0), 16);
        chk("t2_stall_busy", {31'h0, busy}, 1);
        pop_n(4);
        wait_done("t2_done", dc);
        chk("t2_reads", 32'(rd_cnt - r0), 20);

        // Credit is 0; 20 pops must saturate at 16.
        pop_n(20);
        r0 = rd_cnt;
        for (int i = 0; i < 17; i++) push_rd(13'h0600 + 13'(i), 1'b1);
        start_job(13'h0600, 13'd17);
        repeat (40) step();
        chk("sat_reads", 32'(rd_cnt - r0), 16);
        pop_n(1);
        wait_done("sat_done", dc);
        chk("sat_reads_all", 32'(rd_cnt - r0), 17);
        pop_n(16);

        // Writes with no job: granted every cycle.
        dma_w_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_req.push_back('{wr: 1'b1, addr: 13'h0900 + 13'(i), data: 32'h1D1E_0000 + 32'(i)});
            dma_w_addr = 13'h0900 + 13'(i);
            dma_w_data = 32'h1D1E_0000 + 32'(i);
            #1;
            chk("idle_wr_ready", {31'h0, dma_w_ready}, 1);
            step();
        end
        dma_w_valid = 1'b0;

        // Job 3: constant DMA pressure -> 8 writes then 1 read, repeating.
        r0 = rd_cnt;
        for (int i = 0; i < 81; i++) begin
            if (i < 72 && (i % 9) == 8) push_rd(13'h0300 + 13'(i / 9), 1'b1);
            else exp_req.push_back('{wr: 1'b1, addr: 13'h0A00 + 13'(i), data: 32'hDA7A_0000 + 32'(i)});
        end
        start_job(13'h0300, 13'd8);
        for (int i = 0; i < 81; i++) begin
            dma_w_valid = 1'b1;
            dma_w_addr  = 13'h0A00 + 13'(i);
            dma_w_data  = 32'hDA7A_0000 + 32'(i);
            #1;
            if (i == 0) chk("t3_ready_first", {31'h0, dma_w_ready}, 1);
            if (i == 8) chk("t3_ready_streak", {31'h0, dma_w_ready}, 0);
            step();
        end
        dma_w_valid = 1'b0;
        wait_done("t3_done", dc);
        chk("t3_reads", 32'(rd_cnt - r0), 8);
        pop_n(8);

        // Job 4: address wrap.
        fifo_pop = 1'b1;
        push_rd(13'h1FFE, 1'b1);
        push_rd(13'h1FFF, 1'b1);
        push_rd(13'h0000, 1'b1);
        push_rd(13'h0001, 1'b1);
        start_job(13'h1FFE, 13'd4);
        wait_done("t4_done", dc);
        chk("t4_req_left", 32'(exp_req.size()), 0);

        // Restart while busy is ignored.
        r0 = rd_cnt;
        for (int i = 0; i < 4; i++) push_rd(13'h0400 + 13'(i), 1'b1);
        start_job(13'h0400, 13'd4);
        start_job(13'h0800, 13'd2);
        wait_done("t5_done", dc);
        nd = 0;
        repeat (6) begin
            step();
            if (done) nd++;
        end
        chk("t5_second_done", 32'(nd), 0);
        chk("t5_reads", 32'(rd_cnt - r0), 4);

        // Zero-length job.
        r0 = rd_cnt;
        start_job(13'h0700, 13'd0);
        chk("len0_done", {31'h0, done}, 1);
        chk("len0_busy", {31'h0, busy}, 0);
        step();
        chk("len0_done_pulse", {31'h0, done}, 0);
        chk("len0_reads", 32'(rd_cnt - r0), 0);
        fifo_pop = 1'b0;

        // Reset after three of eight reads have issued.
        r0 = rd_cnt;
        for (int i = 0; i < 3; i++) push_rd(13'h0500 + 13'(i), 1'b0);
        start_job(13'h0500, 13'd8);
        repeat (3) step();
        wb_rst_ni = 1'b0;
        #1;
        chk("mrst_busy", {31'h0, busy}, 0);
        chk("mrst_done", {31'h0, done}, 0);
        chk("mrst_bram_valid", {31'h0, bram_in_valid}, 0);
        chk("mrst_bram_wr", {31'h0, bram_wr}, 0);
        chk("mrst_bram_addr", {19'h0, bram_addr}, 0);
        chk("mrst_bram_data", bram_data_in, 0);
        chk("mrst_fifo_push", {31'h0, fifo_push}, 0);
        chk("mrst_fifo_data", fifo_data, 0);
        chk("mrst_err", {31'h0, err_rd_unexp}, 0);
        repeat (2) step();
        wb_rst_ni = 1'b1;
        repeat (16) step();
        chk("mrst_err_late", {31'h0, err_rd_unexp}, 1);
        chk("mrst_idle", {31'h0, busy}, 0);
        chk("mrst_reads", 32'(rd_cnt - r0), 3);

        chk("sb_req_empty", 32'(exp_req.size()), 0);
        chk("sb_push_empty", 32'(exp_push.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
